// File: rtl/pipe_pkg.sv
// Shared widths, slot payload type and helpers for the pipeline-register chain.
package pipe_pkg;

    localparam int unsigned STAGES_MAX = 4;
    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned CTRL_W_DEF = 8;
    localparam int unsigned CNT_W_DEF  = 16;
    localparam int unsigned OCC_W      = 3;

    typedef struct packed {
        logic                  valid;
        logic [CTRL_W_DEF-1:0] ctrl;
        logic [DATA_W_DEF-1:0] data;
    } slot_t;

    // Number of set bits across the deepest chain plus its skid entry.
    function automatic logic [OCC_W-1:0] count_valid(input logic [STAGES_MAX:0] v);
        logic [OCC_W-1:0] n;
        n = '0;
        for (int i = 0; i <= int'(STAGES_MAX); i++) begin
            n = n + OCC_W'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/pipe_stage.sv
// One pipeline slot: loads a beat (or a bubble), is killed by flush, otherwise holds.
module pipe_stage
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned CTRL_W = CTRL_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              flush,
    input  logic              d_valid,
    input  logic [CTRL_W-1:0] d_ctrl,
    input  logic [DATA_W-1:0] d_data,
    output logic              q_valid,
    output logic [CTRL_W-1:0] q_ctrl,
    output logic [DATA_W-1:0] q_data
);

    // Ctrl is forced to zero whenever the slot ends up empty; data may stay stale.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_valid <= 1'b0;
            q_ctrl  <= '0;
            q_data  <= '0;
        end else if (flush) begin
            q_valid <= 1'b0;
            q_ctrl  <= '0;
        end else if (load) begin
            q_valid <= d_valid;
            q_ctrl  <= d_valid ? d_ctrl : '0;
            q_data  <= d_data;
        end
    end

endmodule

// File: rtl/pipe_stage_chain.sv
// Parametrised valid/ready pipeline-register chain with stall, per-stage flush,
// a one-entry input skid buffer and saturating stall/flush statistics.
module pipe_stage_chain
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned CTRL_W = CTRL_W_DEF,
    parameter int unsigned STAGES = 1,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              stall,
    input  logic [STAGES-1:0] flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [OCC_W-1:0]  occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam logic [STAGES-1:0] ONES = '1;

    logic [STAGES-1:0] st_valid;
    logic [CTRL_W-1:0] st_ctrl [STAGES];
    logic [DATA_W-1:0] st_data [STAGES];

    logic [STAGES-1:0] move;
    logic [STAGES-1:0] src_valid;
    logic [CTRL_W-1:0] src_ctrl [STAGES];
    logic [DATA_W-1:0] src_data [STAGES];

    logic              skid_valid;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic              skid_valid_nxt;
    logic              skid_fill;
    logic              accept;

    logic [STAGES_MAX:0] occ_vec;
    logic [STAGES_MAX:0] kill_vec;
    logic [CNT_W:0]      flush_sum;

    assign accept = in_valid & in_ready;

    // A stage takes new contents when some slot at or beyond it is free, or the
    // consumer drains the last stage; this collapses the ready chain to one term.
    always_comb begin
        move = '0;
        for (int k = 0; k < int'(STAGES); k++) begin
            move[k] = ~stall & (out_ready | ~(&(st_valid | ~(ONES << k))));
        end
    end

    // Stage 0 is fed from the skid first, otherwise from the producer.
    always_comb begin
        src_valid    = '0;
        src_valid[0] = skid_valid | accept;
        src_ctrl[0]  = skid_valid ? skid_ctrl : in_ctrl;
        src_data[0]  = skid_valid ? skid_data : in_data;
        for (int k = 1; k < int'(STAGES); k++) begin
            src_valid[k] = st_valid[k-1];
            src_ctrl[k]  = st_ctrl[k-1];
            src_data[k]  = st_data[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        pipe_stage #(
            .DATA_W (DATA_W),
            .CTRL_W (CTRL_W)
        ) u_stage (
            .clk     (clk),
            .reset   (reset),
            .load    (move[k]),
            .flush   (flush[k]),
            .d_valid (src_valid[k]),
            .d_ctrl  (src_ctrl[k]),
            .d_data  (src_data[k]),
            .q_valid (st_valid[k]),
            .q_ctrl  (st_ctrl[k]),
            .q_data  (st_data[k])
        );
    end

    // An accepted beat parks in the skid whenever stage 0 cannot take it.
    assign skid_fill      = accept & ~move[0];
    assign skid_valid_nxt = ~flush[0] & (skid_fill | (skid_valid & ~move[0]));

    // Next-state occupancy and the beats a flush destroys; an input beat killed
    // on the edge it is accepted never occupied a slot and is not counted.
    always_comb begin
        occ_vec  = '0;
        kill_vec = '0;
        for (int k = 0; k < int'(STAGES); k++) begin
            occ_vec[k]  = ~flush[k] & (move[k] ? src_valid[k] : st_valid[k]);
            kill_vec[k] = flush[k] & (move[k] ? ((k != 0) & src_valid[k]) : st_valid[k]);
        end
        occ_vec[STAGES]  = skid_valid_nxt;
        kill_vec[STAGES] = skid_valid & flush[0];
    end

    assign flush_sum = {1'b0, flush_cnt} + (CNT_W+1)'(count_valid(kill_vec));

    always_ff @(posedge clk) begin
        if (reset) begin
            skid_valid <= 1'b0;
            skid_ctrl  <= '0;
            skid_data  <= '0;
            in_ready   <= 1'b1;
            occupancy  <= '0;
            stall_cnt  <= '0;
            flush_cnt  <= '0;
        end else begin
            skid_valid <= skid_valid_nxt;
            if (skid_fill) begin
                skid_ctrl <= in_ctrl;
                skid_data <= in_data;
            end
            in_ready  <= ~skid_valid_nxt;
            occupancy <= count_valid(occ_vec);
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            flush_cnt <= flush_sum[CNT_W] ? '1 : flush_sum[CNT_W-1:0];
        end
    end

    assign out_valid = st_valid[STAGES-1];
    assign out_ctrl  = st_ctrl[STAGES-1];
    assign out_data  = st_data[STAGES-1];

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Self-checking bench for pipe_stage_chain (3 stages): slot-level behavioural model
// compared every cycle, plus hand-computed expectations for the directed scenarios.
module tb_pipe_stage_chain;
    import pipe_pkg::*;

    localparam int STG = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_data;
    logic [7:0]        in_ctrl;
    logic              stall;
    logic [STG-1:0]    flush;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_data;
    logic [7:0]        out_ctrl;
    logic [2:0]        occupancy;
    logic [15:0]       stall_cnt;
    logic [15:0]       flush_cnt;

    pipe_stage_chain #(
        .DATA_W (32),
        .CTRL_W (8),
        .STAGES (STG),
        .CNT_W  (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .stall     (stall),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .occupancy (occupancy),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [7:0] ctrl_of(input logic [31:0] d);
        return {1'b1, d[8:2]};
    endfunction

    // ---------------- behavioural model ----------------
    slot_t       m_st [STG];
    slot_t       m_sk;
    bit          m_in_ready = 1'b1;
    int          m_occ = 0;
    logic [15:0] m_stall_cnt = '0;
    logic [15:0] m_flush_cnt = '0;
    bit          m_acc = 1'b0;
    bit          live  = 1'b0;
    bit          seen_dead = 1'b0;

    always @(posedge clk) begin : model
        slot_t nxt [STG];
        bit    fresh [STG];
        slot_t nsk;
        bit    sk_fresh;
        slot_t inc;
        int    killed;
        bit    acc;
        m_acc = 1'b0;
        if (reset) begin
            for (int k = 0; k < STG; k++) m_st[k] = '0;
            m_sk        = '0;
            m_in_ready  = 1'b1;
            m_occ       = 0;
            m_stall_cnt = '0;
            m_flush_cnt = '0;
            live        = 1'b1;
        end else begin
            acc      = in_valid && m_in_ready;
            m_acc    = acc;
            inc      = '{valid: 1'b1, ctrl: in_ctrl, data: in_data};
            nsk      = m_sk;
            sk_fresh = 1'b0;
            for (int k = 0; k < STG; k++) begin
                nxt[k]   = '0;
                fresh[k] = 1'b0;
            end
            if (stall) begin
                for (int k = 0; k < STG; k++) nxt[k] = m_st[k];
                if (acc) begin
                    nsk      = inc;
                    sk_fresh = 1'b1;
                end
            end else begin
                // Beats slide one place toward the output into any hole ahead of them.
                if (m_st[STG-1].valid && !out_ready) nxt[STG-1] = m_st[STG-1];
                for (int k = STG-2; k >= 0; k--) begin
                    if (m_st[k].valid) begin
                        if (!nxt[k+1].valid) nxt[k+1] = m_st[k];
                        else                 nxt[k]   = m_st[k];
                    end
                end
                if (!nxt[0].valid) begin
                    if (m_sk.valid) begin
                        nxt[0] = m_sk;
                        nsk    = '0;
                    end else if (acc) begin
                        nxt[0]   = inc;
                        fresh[0] = 1'b1;
                    end
                end else if (acc) begin
                    nsk      = inc;
                    sk_fresh = 1'b1;
                end
            end
            killed = 0;
            for (int k = 0; k < STG; k++) begin
                if (flush[k]) begin
                    if (nxt[k].valid && !fresh[k]) killed++;
                    nxt[k].valid = 1'b0;
                    nxt[k].ctrl  = '0;
                end
            end
            if (flush[0]) begin
                if (nsk.valid && !sk_fresh) killed++;
                nsk = '0;
            end
            for (int k = 0; k < STG; k++) m_st[k] = nxt[k];
            m_sk       = nsk;
            m_in_ready = !nsk.valid;
            m_occ      = int'(nsk.valid);
            for (int k = 0; k < STG; k++) m_occ += int'(nxt[k].valid);
            if (stall && m_stall_cnt != 16'hFFFF) m_stall_cnt = m_stall_cnt + 16'd1;
            if (int'(m_flush_cnt) + killed > 65535) m_flush_cnt = 16'hFFFF;
            else m_flush_cnt = 16'(int'(m_flush_cnt) + killed);
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (live) begin
            check("out_valid", 64'(out_valid), 64'(m_st[STG-1].valid));
            check("out_ctrl",  64'(out_ctrl),  64'(m_st[STG-1].ctrl));
            if (m_st[STG-1].valid) check("out_data", 64'(out_data), 64'(m_st[STG-1].data));
            check("in_ready",  64'(in_ready),  64'(m_in_ready));
            check("occupancy", 64'(occupancy), 64'(m_occ));
            check("stall_cnt", 64'(stall_cnt), 64'(m_stall_cnt));
            check("flush_cnt", 64'(flush_cnt), 64'(m_flush_cnt));
            if (out_valid && out_data == 32'hDEAD) seen_dead = 1'b1;
        end
    end

    // ---------------- stimulus ----------------
    logic [31:0] src;

    task automatic run(input int n, input bit iv, input bit st, input logic [STG-1:0] fl, input bit ordy);
        for (int i = 0; i < n; i++) begin
            in_valid  = iv;
            in_data   = src;
            in_ctrl   = ctrl_of(src);
            stall     = st;
            flush     = fl;
            out_ready = ordy;
            @(posedge clk);
            #1;
            if (m_acc) src = src + 32'd4;
        end
    endtask

    initial begin
        bit          t1_v [6];
        logic [31:0] t1_d [6];
        logic [2:0]  fl;
        t1_v = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        t1_d = '{32'h0, 32'h0, 32'h100, 32'h104, 32'h108, 32'h0};

        reset = 1'b1;
        src   = 32'h0;
        run(2, 1'b0, 1'b0, 3'b000, 1'b0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_occ", 64'(occupancy), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        reset = 1'b0;

        // Streaming latency: three beats, one per cycle.
        src = 32'h100;
        for (int c = 0; c < 6; c++) begin
            run(1, c < 3, 1'b0, 3'b000, 1'b1);
            check("t1_out_valid", 64'(out_valid), 64'(t1_v[c]));
            if (t1_v[c]) check("t1_out_data", 64'(out_data), 64'(t1_d[c]));
        end

        // Two stall cycles with the output valid.
        src = 32'h200;
        run(3, 1'b1, 1'b0, 3'b000, 1'b1);
        check("t2_pre_data", 64'(out_data), 64'h200);
        for (int c = 0; c < 2; c++) begin
            run(1, 1'b1, 1'b1, 3'b000, 1'b1);
            check("t2_hold_valid", 64'(out_valid), 64'd1);
            check("t2_hold_data", 64'(out_data), 64'h200);
        end
        check("t2_stall_cnt", 64'(stall_cnt), 64'd2);
        check("t2_in_ready", 64'(in_ready), 64'd0);
        run(1, 1'b0, 1'b0, 3'b000, 1'b1);
        check("t2_next_data", 64'(out_data), 64'h204);
        check("t2_occ", 64'(occupancy), 64'd3);
        run(6, 1'b0, 1'b0, 3'b000, 1'b1);
        check("t2_drained", 64'(occupancy), 64'd0);

        // Flush the two youngest of three held beats.
        src = 32'h300;
        run(3, 1'b1, 1'b0, 3'b000, 1'b0);
        check("t3_full", 64'(occupancy), 64'd3);
        run(1, 1'b0, 1'b0, 3'b011, 1'b0);
        check("t3_flush_cnt", 64'(flush_cnt), 64'd2);
        check("t3_occ", 64'(occupancy), 64'd1);
        check("t3_out_data", 64'(out_data), 64'h300);
        run(1, 1'b0, 1'b0, 3'b000, 1'b1);
        check("t3_empty_valid", 64'(out_valid), 64'd0);
        check("t3_empty_ctrl", 64'(out_ctrl), 64'd0);
        run(3, 1'b0, 1'b0, 3'b000, 1'b1);

        // Backpressure fills the chain and the skid.
        src = 32'h400;
        run(5, 1'b1, 1'b0, 3'b000, 1'b0);
        check("t4_occ", 64'(occupancy), 64'd4);
        check("t4_in_ready", 64'(in_ready), 64'd0);
        check("t4_out_data", 64'(out_data), 64'h400);
        run(1, 1'b0, 1'b0, 3'b000, 1'b1);
        check("t4_rel_data", 64'(out_data), 64'h404);
        check("t4_rel_ready", 64'(in_ready), 64'd1);
        check("t4_rel_occ", 64'(occupancy), 64'd3);
        run(1, 1'b0, 1'b0, 3'b000, 1'b1);
        check("t4_data_408", 64'(out_data), 64'h408);
        run(1, 1'b0, 1'b0, 3'b000, 1'b1);
        check("t4_data_40c", 64'(out_data), 64'h40C);
        run(1, 1'b0, 1'b0, 3'b000, 1'b1);
        check("t4_done", 64'(out_valid), 64'd0);

        // A beat accepted on the same edge as flush[0] is discarded.
        src = 32'hDEAD;
        run(1, 1'b1, 1'b0, 3'b001, 1'b1);
        check("t6_occ", 64'(occupancy), 64'd0);
        check("t6_flush_cnt", 64'(flush_cnt), 64'd2);
        src = 32'h600;
        run(2, 1'b1, 1'b0, 3'b000, 1'b1);
        run(5, 1'b0, 1'b0, 3'b000, 1'b1);
        check("t6_no_dead", 64'(seen_dead), 64'd0);

        // Interleaved valid, stall, flush and backpressure patterns.
        src = 32'h700;
        for (int i = 0; i < 80; i++) begin
            if (i % 11 == 5)      fl = 3'b010;
            else if (i % 13 == 8) fl = 3'b001;
            else if (i % 17 == 12) fl = 3'b100;
            else                  fl = 3'b000;
            run(1, (i % 3) != 2, (i % 7) == 3, fl, (i % 5) != 1);
        end
        run(8, 1'b0, 1'b0, 3'b000, 1'b1);
        check("mix_drained", 64'(occupancy), 64'd0);

        // Reset with the chain and skid full.
        src = 32'h500;
        run(5, 1'b1, 1'b0, 3'b000, 1'b0);
        check("t5_full", 64'(occupancy), 64'd4);
        reset = 1'b1;
        run(1, 1'b1, 1'b0, 3'b000, 1'b0);
        check("t5_out_valid", 64'(out_valid), 64'd0);
        check("t5_out_ctrl", 64'(out_ctrl), 64'd0);
        check("t5_occ", 64'(occupancy), 64'd0);
        check("t5_in_ready", 64'(in_ready), 64'd1);
        check("t5_stall_cnt", 64'(stall_cnt), 64'd0);
        check("t5_flush_cnt", 64'(flush_cnt), 64'd0);
        reset = 1'b0;
        run(2, 1'b0, 1'b0, 3'b000, 1'b1);
        check("t5_stay_empty", 64'(out_valid), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
